// File: rtl/fir_sym_mac_sched.sv
// Time-shared symmetric FIR: one pre-adder/multiplier/accumulator walks the tap pairs per sample.
// Latency TAPS/2+2 cycles from accept to out_valid; in_ready low while busy, offered samples then dropped and flagged in overrun.
// Optional writable coefficient file when FIR_SCHED_COEF_LOAD_EN is defined (ports coef_we/coef_addr/coef_wdata).
module fir_sym_mac_sched #(
    parameter int TAPS = 20,
    parameter int DW   = 12,
    parameter int CW   = 13,
    parameter int AW   = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    output logic [AW-2:0] data_out,
    output logic          busy,
    output logic          overrun
`ifdef FIR_SCHED_COEF_LOAD_EN
    ,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_wdata
`endif
);

    localparam int NP  = TAPS / 2;
    localparam int PW  = $clog2(TAPS);
    localparam int KW  = (NP > 1) ? $clog2(NP) : 1;
    localparam int PRW = DW + 1 + CW;

    localparam logic [PW:0]   TAPS_X   = (PW+1)'(TAPS);
    localparam logic [KW-1:0] K_LAST   = KW'(NP - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(TAPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [CW-1:0] default_coef(input int k);
        case (k)
            0:       return CW'(1);
            1:       return CW'(11);
            2:       return CW'(63);
            3:       return CW'(213);
            4:       return CW'(541);
            5:       return CW'(1107);
            6:       return CW'(1901);
            7:       return CW'(2807);
            8:       return CW'(3615);
            9:       return CW'(4095);
            default: return '0;
        endcase
    endfunction

    logic [1:0]     r_state;
    logic [DW-1:0]  r_buf [0:TAPS-1];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_base;
    logic [KW-1:0]  r_k;
    logic [AW-1:0]  r_acc;
    logic [PRW-1:0] r_prod;
    logic [AW-2:0]  r_dout;
    logic           r_ovld;
    logic           r_ovr;

    logic           w_accept;
    logic [PW:0]    w_sum_a;
    logic [PW:0]    w_sum_b;
    logic [PW-1:0]  w_idx_a;
    logic [PW-1:0]  w_idx_b;
    logic [DW-1:0]  w_samp_a;
    logic [DW-1:0]  w_samp_b;
    logic [DW:0]    w_pair;
    logic [CW-1:0]  w_coef;
    logic [PRW-1:0] w_pair_x;
    logic [PRW-1:0] w_coef_x;
    logic [PRW-1:0] w_prod;
    logic [AW-1:0]  w_prod_x;
    logic           w_unused_lsb;

    assign in_ready  = rst_n & (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_ovld;
    assign data_out  = r_dout;
    assign overrun   = r_ovr;

    // Pair indices base-k and base-(TAPS-1-k), both reduced mod TAPS by one conditional subtract.
    assign w_sum_a  = {1'b0, r_base} + TAPS_X - {{(PW+1-KW){1'b0}}, r_k};
    assign w_sum_b  = {1'b0, r_base} + {{(PW+1-KW){1'b0}}, r_k} + (PW+1)'(1);
    assign w_idx_a  = (w_sum_a >= TAPS_X) ? PW'(w_sum_a - TAPS_X) : PW'(w_sum_a);
    assign w_idx_b  = (w_sum_b >= TAPS_X) ? PW'(w_sum_b - TAPS_X) : PW'(w_sum_b);
    assign w_samp_a = r_buf[w_idx_a];
    assign w_samp_b = r_buf[w_idx_b];

    assign w_pair   = {w_samp_a[DW-1], w_samp_a} + {w_samp_b[DW-1], w_samp_b};
    assign w_pair_x = {{CW{w_pair[DW]}}, w_pair};
    assign w_coef_x = {{(DW+1){w_coef[CW-1]}}, w_coef};
    assign w_prod   = w_pair_x * w_coef_x;
    assign w_prod_x = {{(AW-PRW){r_prod[PRW-1]}}, r_prod};
    assign w_unused_lsb = r_acc[0];

`ifdef FIR_SCHED_COEF_LOAD_EN
    logic [CW-1:0] r_coef [0:NP-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) r_coef[i] <= default_coef(i);
        end else if (coef_we && (r_state == S_IDLE) && !w_accept && (int'(coef_addr) < NP)) begin
            r_coef[coef_addr[KW-1:0]] <= coef_wdata;
        end
    end

    assign w_coef = r_coef[r_k];
`else
    assign w_coef = default_coef(int'(r_k));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
            r_wr    <= '0;
            r_base  <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_prod  <= '0;
            r_dout  <= '0;
            r_ovld  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovld <= 1'b0;
            if (in_valid && !in_ready) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_buf[r_wr] <= data_in;
                        r_base      <= r_wr;
                        r_wr        <= (r_wr == PTR_LAST) ? '0 : r_wr + PW'(1);
                        r_acc       <= '0;
                        r_prod      <= '0;
                        r_k         <= '0;
                        r_state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Product is registered; the accumulator trails it by one cycle.
                    r_prod <= w_prod;
                    r_acc  <= r_acc + w_prod_x;
                    if (r_k == K_LAST) r_state <= S_DRAIN;
                    else               r_k     <= r_k + KW'(1);
                end
                S_DRAIN: begin
                    r_acc   <= r_acc + w_prod_x;
                    r_state <= S_DONE;
                end
                default: begin
                    r_dout  <= r_acc[AW-1:1];
                    r_ovld  <= 1'b1;
                    r_k     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
